// File: rtl/fft_sink_pkg.sv
// fft_sink_pkg -- shared types and constants for the FFT result sink.
//   sink_state_t : frame FSM states
//   bin_idx_t    : bin index (BIN_IDX_W bits)
//   mag_t        : magnitude-squared (BIN_MAG_W bits)
//   MAX_FRAME    : frame length implied by a SAMP_NUMBER of 0
package fft_sink_pkg;

  localparam int BIN_IDX_W = 12;
  localparam int BIN_MAG_W = 32;
  localparam int MAX_FRAME = 4096;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } sink_state_t;

  typedef logic [BIN_IDX_W-1:0] bin_idx_t;
  typedef logic [BIN_MAG_W-1:0] mag_t;

endpackage

// File: rtl/fft_bin_sink_if.sv
// fft_bin_sink_if -- bin input channel from the FFT core plus the
// magnitude output channel toward the downstream consumer.
//   wdata/wvalid/wready              : FFT write channel, {re[31:16], im[15:0]}
//   bin_mag/bin_index/bin_valid/bin_ready : FIFO head, popped on valid&&ready
// Modports: slave = the sink, master = whoever drives bins and pops results.
interface fft_bin_sink_if #(
  parameter int IDX_W = 12,
  parameter int MAG_W = 32
);
  logic [31:0]      wdata;
  logic             wvalid;
  logic             wready;
  logic [MAG_W-1:0] bin_mag;
  logic [IDX_W-1:0] bin_index;
  logic             bin_valid;
  logic             bin_ready;

  modport slave (
    input  wdata, wvalid, bin_ready,
    output wready, bin_mag, bin_index, bin_valid
  );

  modport master (
    output wdata, wvalid, bin_ready,
    input  wready, bin_mag, bin_index, bin_valid
  );
endinterface

// File: rtl/fft_bin_sink_fifo.sv
// sync_fifo -- first-word-fall-through synchronous FIFO with occupancy count.
//   clk, rst (sync, active high)
//   push/din  : write when not full (or when a pop frees the slot)
//   pop       : ignored while empty
//   dout/valid: head entry, dout forced to 0 when empty
//   count     : current occupancy, 0..DEPTH
module sync_fifo #(
  parameter int WIDTH = 44,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign do_pop  = pop && (count != '0);
  // full + simultaneous pop is legal: the popped slot is reused this edge
  assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // storage needs no reset; emptiness is tracked by count
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign valid = (count != '0);
  assign dout  = valid ? mem[rd_ptr] : '0;

endmodule

// File: rtl/fft_bin_sink.sv
// fft_bin_sink -- consumer of the FFT core's result write channel.
// Tags each accepted bin with its index in the frame, squares it through a
// two-stage pipeline (products, then sum written into the FIFO), buffers
// {mag, index} in a FWFT FIFO and tracks the peak bin of each frame.
//   clk, Reset      : clock, synchronous active-high reset
//   bus (slave)     : wdata/wvalid/wready in, bin_mag/bin_index/bin_valid/bin_ready out
//   i_SAMP_NUMBER   : frame length in bins, 0 = 4096, latched on a frame's first accept
//   o_FRAME_DONE    : pulse when the frame's last bin lands in the FIFO
//   o_PEAK_INDEX/o_PEAK_MAG : largest bin of the last completed frame
// Build option: define FFT_SINK_PEAK_EN to build the peak tracker; otherwise
// the peak outputs are tied to 0.
module fft_bin_sink
  import fft_sink_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int IDX_W = BIN_IDX_W,
  parameter int MAG_W = BIN_MAG_W
) (
  input  logic             clk,
  input  logic             Reset,
  fft_bin_sink_if.slave    bus,
  input  logic [IDX_W-1:0] i_SAMP_NUMBER,
  output logic             o_FRAME_DONE,
  output logic [IDX_W-1:0] o_PEAK_INDEX,
  output logic [MAG_W-1:0] o_PEAK_MAG
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  sink_state_t      state;
  logic [IDX_W-1:0] idx;       // index the next accepted bin gets (in S_RUN)
  logic [IDX_W-1:0] last_idx;  // len-1; SAMP_NUMBER 0 wraps to 4095 = 4096 bins

  logic             acc;
  logic [IDX_W-1:0] cur_idx;
  logic             cur_last;

  // stage 1 registers
  logic             s1_vld;
  logic [MAG_W-1:0] s1_re_sq, s1_im_sq;
  logic [IDX_W-1:0] s1_idx;
  logic             s1_last;
  logic [MAG_W-1:0] s1_mag;

  logic signed [31:0] re32, im32, re_prod, im_prod;

  logic [CNT_W-1:0]       fifo_count;
  logic [MAG_W+IDX_W-1:0] fifo_dout;

  // Room is counted including the bin in stage 1, so the pipeline never stalls.
  assign bus.wready = !Reset && (state != S_DRAIN)
                      && ((fifo_count + CNT_W'(s1_vld)) < CNT_W'(DEPTH));
  assign acc        = bus.wvalid && bus.wready;

  // first bin of a frame is taken in S_IDLE before idx/last_idx are loaded
  assign cur_idx  = (state == S_IDLE) ? '0 : idx;
  assign cur_last = (state == S_IDLE) ? (i_SAMP_NUMBER == IDX_W'(1))
                                      : (idx == last_idx);

  // ---------------- frame FSM ----------------
  always_ff @(posedge clk) begin
    if (Reset) begin
      state    <= S_IDLE;
      idx      <= '0;
      last_idx <= '0;
    end else begin
      case (state)
        S_IDLE: if (acc) begin
          last_idx <= i_SAMP_NUMBER - 1'b1;
          idx      <= IDX_W'(1);
          state    <= (i_SAMP_NUMBER == IDX_W'(1)) ? S_DRAIN : S_RUN;
        end
        S_RUN: if (acc) begin
          idx <= idx + 1'b1;
          if (idx == last_idx) state <= S_DRAIN;
        end
        // leave once the last bin is in the FIFO (FRAME_DONE cycle)
        S_DRAIN: if (o_FRAME_DONE) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // ---------------- squarer pipeline ----------------
  assign re32    = 32'(signed'(bus.wdata[31:16]));
  assign im32    = 32'(signed'(bus.wdata[15:0]));
  assign re_prod = re32 * re32;
  assign im_prod = im32 * im32;
  // each square <= 2^30, so the sum fits unsigned 32 bits
  assign s1_mag  = s1_re_sq + s1_im_sq;

  always_ff @(posedge clk) begin
    if (Reset) begin
      s1_vld       <= 1'b0;
      s1_re_sq     <= '0;
      s1_im_sq     <= '0;
      s1_idx       <= '0;
      s1_last      <= 1'b0;
      o_FRAME_DONE <= 1'b0;
    end else begin
      s1_vld <= acc;
      if (acc) begin
        s1_re_sq <= MAG_W'(re_prod);
        s1_im_sq <= MAG_W'(im_prod);
        s1_idx   <= cur_idx;
        s1_last  <= cur_last;
      end
      o_FRAME_DONE <= s1_vld && s1_last;
    end
  end

  // ---------------- result FIFO (stage 2 write) ----------------
  sync_fifo #(.WIDTH(MAG_W + IDX_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (Reset),
    .push  (s1_vld),
    .din   ({s1_mag, s1_idx}),
    .pop   (bus.bin_ready),
    .dout  (fifo_dout),
    .valid (bus.bin_valid),
    .count (fifo_count)
  );

  assign bus.bin_mag   = fifo_dout[MAG_W+IDX_W-1:IDX_W];
  assign bus.bin_index = fifo_dout[IDX_W-1:0];

  // ---------------- peak tracker ----------------
`ifdef FFT_SINK_PEAK_EN
  logic [MAG_W-1:0] run_mag;
  logic [IDX_W-1:0] run_idx;
  logic             take;

  // strictly greater keeps the earlier index on ties; bin 0 seeds the frame
  assign take = (s1_idx == '0) || (s1_mag > run_mag);

  always_ff @(posedge clk) begin
    if (Reset) begin
      run_mag      <= '0;
      run_idx      <= '0;
      o_PEAK_MAG   <= '0;
      o_PEAK_INDEX <= '0;
    end else if (s1_vld) begin
      if (take) begin
        run_mag <= s1_mag;
        run_idx <= s1_idx;
      end
      if (s1_last) begin
        o_PEAK_MAG   <= take ? s1_mag : run_mag;
        o_PEAK_INDEX <= take ? s1_idx : run_idx;
      end
    end
  end
`else
  assign o_PEAK_MAG   = '0;
  assign o_PEAK_INDEX = '0;
`endif

endmodule

// File: tb/tb_fft_bin_sink.sv
module tb_fft_bin_sink;
  import fft_sink_pkg::*;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        Reset;
  logic [11:0] samp;
  logic        frame_done;
  logic [11:0] pk_idx_o;
  logic [31:0] pk_mag_o;

  fft_bin_sink_if #(.IDX_W(12), .MAG_W(32)) bus ();

  fft_bin_sink #(.DEPTH(DEPTH), .IDX_W(12), .MAG_W(32)) dut (
    .clk           (clk),
    .Reset         (Reset),
    .bus           (bus),
    .i_SAMP_NUMBER (samp),
    .o_FRAME_DONE  (frame_done),
    .o_PEAK_INDEX  (pk_idx_o),
    .o_PEAK_MAG    (pk_mag_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { longint mag; int idx; int acyc; } ent_t;
  ent_t   q[$];           // accepted, not yet popped
  int     cyc = 0;
  int     low_until = -10; // WREADY forced low through this cycle
  int     fd_cyc = -10;    // cycle FRAME_DONE is due
  bit     in_frame = 0;
  int     pos = 0, len = 0;
  longint run_max = 0, pend_mag = 0, m_pk_mag = 0;
  int     run_idx = 0, pend_idx = 0, m_pk_idx = 0;
  int     n_done = 0;
  int     got_idx[$];
  longint got_mag[$];

  function automatic longint sq(input logic [31:0] d);
    longint re, im;
    re = longint'($signed(d[31:16]));
    im = longint'($signed(d[15:0]));
    return re*re + im*im;
  endfunction

  // One cycle: drive inputs, check outputs against the model, advance.
  task automatic tick(input bit v, input logic [31:0] d, input logic [11:0] sn,
                      input bit br, input bit rs, output bit acc);
    bit   rdy, vld;
    ent_t e;
    acc = 0;
    Reset = rs; bus.wvalid = v; bus.wdata = d; samp = sn; bus.bin_ready = br;
    #1;
    if (rs) begin
      chk("wready_in_reset", bus.wready, 0);
      q.delete(); in_frame = 0; low_until = -10; fd_cyc = -10;
      run_max = 0; run_idx = 0; m_pk_mag = 0; m_pk_idx = 0;
    end else begin
      if (cyc == fd_cyc) begin m_pk_mag = pend_mag; m_pk_idx = pend_idx; end
      rdy = (cyc > low_until) && (q.size() < DEPTH);
      vld = (q.size() > 0) && (q[0].acyc <= cyc - 2);
      chk("wready", bus.wready, rdy);
      chk("bin_valid", bus.bin_valid, vld);
      if (vld) begin
        chk("bin_mag", bus.bin_mag, q[0].mag);
        chk("bin_index", bus.bin_index, q[0].idx);
      end
      chk("frame_done", frame_done, cyc == fd_cyc);
      if (frame_done) n_done++;
`ifdef FFT_SINK_PEAK_EN
      chk("peak_index", pk_idx_o, m_pk_idx);
      chk("peak_mag", pk_mag_o, m_pk_mag);
`else
      chk("peak_index_off", pk_idx_o, 0);
      chk("peak_mag_off", pk_mag_o, 0);
`endif
      if (vld && br) begin
        got_idx.push_back(int'(bus.bin_index));
        got_mag.push_back(longint'(bus.bin_mag));
        void'(q.pop_front());
      end
      if (v && rdy) begin
        acc = 1;
        if (!in_frame) begin
          len = (sn == 0) ? MAX_FRAME : int'(sn);
          pos = 0; in_frame = 1;
        end
        e.mag = sq(d); e.idx = pos; e.acyc = cyc;
        q.push_back(e);
        if (pos == 0 || e.mag > run_max) begin run_max = e.mag; run_idx = pos; end
        if (pos == len - 1) begin
          in_frame = 0; pend_mag = run_max; pend_idx = run_idx;
          fd_cyc = cyc + 2; low_until = cyc + 2;
        end else pos++;
      end
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic send(input logic [31:0] d, input logic [11:0] sn, input bit br);
    bit a;
    int n;
    n = 0;
    do begin tick(1, d, sn, br, 0, a); n++; end while (!a && n < 60);
    if (!a) begin
      checks++; errors++;
      $display("FAIL send_timeout: got no accept in %0d cycles expected accept", n);
    end
  endtask

  task automatic idle(input int n, input bit br);
    bit a;
    for (int i = 0; i < n; i++) tick(0, 32'd0, samp, br, 0, a);
  endtask

  typedef struct {
    logic [31:0] d;  logic [11:0] sn;
    longint mag;     int idx;
    bit last;        int pk_idx;  longint pk_mag;
  } vec_t;
  vec_t tbl [12];

  initial begin : main
    bit a;
    int n0, n_acc, guard;

    tbl[0]  = '{32'h0001_0000, 12'd4, 1, 0, 0, 0, 0};
    tbl[1]  = '{32'h0000_FFFD, 12'd4, 9, 1, 0, 0, 0};
    tbl[2]  = '{32'h0002_0002, 12'd4, 8, 2, 0, 0, 0};
    tbl[3]  = '{32'hFFFF_0001, 12'd4, 2, 3, 1, 1, 9};
    tbl[4]  = '{32'h8000_8000, 12'd2, 64'h8000_0000, 0, 0, 0, 0};
    tbl[5]  = '{32'h7FFF_0000, 12'd2, 64'h3FFF_0001, 1, 1, 0, 64'h8000_0000};
    tbl[6]  = '{32'h0001_0002, 12'd3, 5, 0, 0, 0, 0};
    tbl[7]  = '{32'h0002_0001, 12'd3, 5, 1, 0, 0, 0};
    tbl[8]  = '{32'hFFFE_FFFF, 12'd3, 5, 2, 1, 0, 5};
    tbl[9]  = '{32'h0000_0000, 12'd3, 0, 0, 0, 0, 0};
    tbl[10] = '{32'h0000_0000, 12'd3, 0, 1, 0, 0, 0};
    tbl[11] = '{32'h0002_0002, 12'd3, 8, 2, 1, 2, 8};

    Reset = 1; bus.wvalid = 0; bus.wdata = 0; bus.bin_ready = 0; samp = 12'd4;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) tick(0, 32'd0, 12'd4, 0, 1, a);
    idle(2, 1);   // reset values checked by the model

    // ---- table: basic frame, extremes, ties ----
    got_idx.delete(); got_mag.delete();
    for (int i = 0; i < 12; i++) begin
      send(tbl[i].d, tbl[i].sn, 1);
      if (tbl[i].last) begin
        idle(3, 1);
`ifdef FFT_SINK_PEAK_EN
        chk("tbl_peak_index", pk_idx_o, tbl[i].pk_idx);
        chk("tbl_peak_mag", pk_mag_o, tbl[i].pk_mag);
`else
        chk("tbl_peak_index_off", pk_idx_o, 0);
`endif
      end
    end
    chk("tbl_count", got_mag.size(), 12);
    for (int i = 0; i < 12 && i < got_mag.size(); i++) begin
      chk("tbl_mag", got_mag[i], tbl[i].mag);
      chk("tbl_idx", got_idx[i], tbl[i].idx);
    end
    chk("tbl_frames", n_done, 4);

    // ---- backpressure: 20-bin frame with the consumer stalled ----
    got_idx.delete(); got_mag.delete();
    n_acc = 0;
    for (int i = 0; i < 30; i++) begin
      tick(1, $urandom(), 12'd20, 0, 0, a);
      n_acc += int'(a);
    end
    chk("bp_accepts_stalled", n_acc, 16);
    guard = 0;
    while (n_acc < 20 && guard < 100) begin
      tick(1, $urandom(), 12'd20, 1, 0, a);
      n_acc += int'(a); guard++;
    end
    idle(24, 1);
    chk("bp_count", got_idx.size(), 20);
    for (int i = 0; i < 20 && i < got_idx.size(); i++) chk("bp_order", got_idx[i], i);

    // ---- single-bin frames ----
    got_idx.delete(); got_mag.delete();
    n0 = n_done;
    for (int i = 0; i < 3; i++) send($urandom(), 12'd1, 1);
    idle(3, 1);
    chk("len1_done", n_done - n0, 3);
    chk("len1_count", got_idx.size(), 3);
    foreach (got_idx[i]) chk("len1_idx", got_idx[i], 0);

    // ---- reset in the middle of a frame ----
    n0 = n_done;
    send(32'h0003_0004, 12'd4, 0);
    send(32'h0005_0000, 12'd4, 0);
    tick(0, 32'd0, 12'd4, 0, 1, a);
    chk("rst_valid", bus.bin_valid, 0);
    idle(4, 1);
    chk("rst_no_done", n_done - n0, 0);
    got_idx.delete(); got_mag.delete();
    send(32'h0001_0001, 12'd2, 1);
    send(32'h0000_0002, 12'd2, 1);
    idle(3, 1);
    chk("rst_restart_count", got_idx.size(), 2);
    if (got_idx.size() == 2) begin
      chk("rst_restart_idx0", got_idx[0], 0);
      chk("rst_restart_idx1", got_idx[1], 1);
    end

    // ---- randomized traffic against the model ----
    for (int i = 0; i < 600; i++)
      tick(($urandom() % 4) != 0, $urandom(), 12'(1 + $urandom() % 7),
           ($urandom() % 3) != 0, ($urandom() % 250) == 0, a);
    idle(30, 1);
    chk("final_drained", bus.bin_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
